// File: rtl/instr_fetch_decode_if.sv
// instr_fetch_decode_if: IRAM read port plus decoded-instruction handoff to execute.
interface instr_fetch_decode_if;
    logic [1:0] Control;
    logic [15:0] InstrAddr;
    logic [15:0] InstrIn;
    logic exec_ready;
    logic zero_flag;
    logic instr_valid;
    logic [3:0] opcode;
    logic [4:0] op_a;
    logic [4:0] op_b;
    logic [15:0] imm;
    logic [15:0] pc;
    logic halted;
    logic addr_err;
    modport master (
        output Control, InstrAddr, instr_valid, opcode, op_a, op_b, imm, pc, halted, addr_err,
        input InstrIn, exec_ready, zero_flag
    );
    modport slave (
        input Control, InstrAddr, instr_valid, opcode, op_a, op_b, imm, pc, halted, addr_err,
        output InstrIn, exec_ready, zero_flag
    );
endinterface

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetches one- and two-word instructions from IRAM, resolves JMPZ locally
// and hands every other executable instruction to the execute stage with a valid/ready handshake.
module instr_fetch_decode #(
    parameter logic [15:0] START_ADDR = 16'd0,
    parameter logic [15:0] ADDR_LIMIT = 16'd64
) (
    input logic clock,
    input logic resetn,
    input logic start,
    instr_fetch_decode_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, FETCH_IMM, WAIT_IMM, ISSUE, HALT} state_t;
    state_t state, next;
    logic [15:0] pc_r, imm_r, fa;
    logic [13:0] ir;
    logic [3:0] rd_op;
    logic halted_r, err_r, over, jmpz, rd, valid;
    // The immediate word sits right after its opcode word; the PC only moves on retirement.
    assign fa = (state == FETCH_IMM) ? pc_r + 16'd1 : pc_r;
    assign over = fa >= ADDR_LIMIT;
    assign jmpz = ir[13:10] == 4'd15;
    assign rd_op = bus.InstrIn[15:12];
    assign rd = (state == FETCH || state == FETCH_IMM) && !over;
    assign valid = state == ISSUE && !jmpz;
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE: next = start ? FETCH : IDLE;
            FETCH: next = over ? HALT : WAIT;
            FETCH_IMM: next = over ? HALT : WAIT_IMM;
            WAIT: next = rd_op == 4'd0 ? FETCH : rd_op == 4'd1 ? HALT :
                         (rd_op == 4'd4 || rd_op == 4'd15) ? FETCH_IMM : ISSUE;
            WAIT_IMM: next = ISSUE;
            ISSUE: next = bus.exec_ready ? FETCH : ISSUE;
            default: next = HALT;
        endcase
    end
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pc_r <= START_ADDR;
            ir <= '0;
            imm_r <= '0;
            halted_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            if (state == IDLE && start) pc_r <= START_ADDR;
            if ((state == FETCH || state == FETCH_IMM) && over) err_r <= 1'b1;
            if (state == WAIT) begin
                ir <= bus.InstrIn[15:2];
                imm_r <= '0;
                if (rd_op == 4'd0) pc_r <= pc_r + 16'd1;
                if (rd_op == 4'd1) halted_r <= 1'b1;
            end
            if (state == WAIT_IMM) imm_r <= bus.InstrIn;
            // JMPZ waits for execute to drain so zero_flag reflects every older instruction.
            if (state == ISSUE && bus.exec_ready)
                pc_r <= jmpz ? (bus.zero_flag ? pc_r + 16'd2 : imm_r)
                             : pc_r + (ir[13:10] == 4'd4 ? 16'd2 : 16'd1);
        end
    end
    always_comb begin
        bus.Control = {1'b0, rd};
        bus.InstrAddr = rd ? fa : 16'd0;
        bus.instr_valid = valid;
        bus.opcode = ir[13:10];
        bus.op_a = ir[9:5];
        bus.op_b = ir[4:0];
        bus.imm = imm_r;
        bus.pc = valid ? pc_r : 16'd0;
        bus.halted = halted_r;
        bus.addr_err = err_r;
    end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed checks of timing/boundaries plus randomized programs
// scored against an instruction-level walk of the program.
module tb_instr_fetch_decode;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic start1 = 1'b0;
    always #5 clock = ~clock;

    instr_fetch_decode_if i0();
    instr_fetch_decode_if i1();
    instr_fetch_decode u0 (.clock(clock), .resetn(resetn), .start(start), .bus(i0));
    instr_fetch_decode #(.START_ADDR(16'd63)) u1 (.clock(clock), .resetn(resetn), .start(start1), .bus(i1));

    logic [15:0] mem [0:127];
    always @(posedge clock) begin
        i0.InstrIn <= mem[i0.InstrAddr[6:0]];
        i1.InstrIn <= mem[i1.InstrAddr[6:0]];
    end

    int n_tests = 0;
    int n_fail = 0;
    int issued = 0;
    logic sb_on = 1'b0;
    logic [45:0] expq[$];
    logic [15:0] fetchq[$];
    logic prev_ctl = 1'b0;
    logic prev_stall = 1'b0;
    logic [64:0] prev_snap = '0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [64:0] snap();
        return {i0.Control, i0.InstrAddr, i0.instr_valid, i0.opcode, i0.op_a, i0.op_b, i0.imm, i0.pc};
    endfunction

    function automatic logic [45:0] pack(input logic [15:0] p, input logic [15:0] im, input logic [15:0] w);
        return {p, im, w[15:12], w[11:7], w[6:2]};
    endfunction

    always @(negedge clock) begin
        if (!resetn) begin
            prev_ctl <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            check("ctl_b2b", {79'd0, prev_ctl && i0.Control == 2'd1}, 80'd0);
            if (prev_stall) check("stall_hold", {15'd0, snap()}, {15'd0, prev_snap});
            if (i0.Control == 2'd1) fetchq.push_back(i0.InstrAddr);
            if (i0.instr_valid && i0.exec_ready) begin
                issued <= issued + 1;
                if (sb_on) begin
                    check("issue_q", {79'd0, expq.size() != 0}, 80'd1);
                    if (expq.size() != 0)
                        check("issue", {34'd0, i0.pc, i0.imm, i0.opcode, i0.op_a, i0.op_b}, {34'd0, expq.pop_front()});
                end
            end
            prev_ctl <= i0.Control == 2'd1;
            prev_stall <= i0.instr_valid && !i0.exec_ready;
            prev_snap <= snap();
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Instruction-level walk: status 0 = still running at the step bound, 1 = END, 2 = bad address.
    task automatic build_model(input logic zf, output int st, output int n);
        logic [15:0] p, w;
        p = 16'd0;
        st = 0;
        n = 0;
        for (int s = 0; s < 300 && st == 0; s++) begin
            if (p >= 16'd64) st = 2;
            else begin
                w = mem[p[6:0]];
                case (w[15:12])
                    4'd0: p = p + 16'd1;
                    4'd1: st = 1;
                    4'd4, 4'd15: begin
                        if (p + 16'd1 >= 16'd64) st = 2;
                        else if (w[15:12] == 4'd4) begin
                            expq.push_back(pack(p, mem[p[6:0] + 7'd1], w));
                            n++;
                            p = p + 16'd2;
                        end else p = zf ? p + 16'd2 : mem[p[6:0] + 7'd1];
                    end
                    default: begin
                        expq.push_back(pack(p, 16'd0, w));
                        n++;
                        p = p + 16'd1;
                    end
                endcase
            end
        end
    endtask

    initial begin
        logic [64:0] s;
        int base, k, st, n;
        logic zf;
        logic [3:0] op;
        i0.exec_ready = 1'b0;
        i0.zero_flag = 1'b0;
        i1.exec_ready = 1'b1;
        i1.zero_flag = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 16'd0;
        mem[0] = 16'b0010000001111100;
        mem[1] = 16'b0100000000000100;
        mem[2] = 16'd7;
        mem[3] = 16'h1000;
        mem[63] = 16'b0100000000000100;

        tick();
        check("reset_out", {17'd0, i0.Control, i0.InstrAddr, i0.instr_valid, i0.opcode, i0.op_a, i0.op_b,
                            i0.imm, i0.pc, i0.halted, i0.addr_err}, 80'd0);
        resetn = 1'b1;
        tick();
        tick();
        check("idle_wait", {62'd0, i0.Control, i0.InstrAddr}, 80'd0);

        base = issued;
        pulse_start();
        check("c1_fetch", {62'd0, i0.Control, i0.InstrAddr}, {62'd0, 2'd1, 16'd0});
        tick();
        check("c2_wait", {78'd0, i0.Control}, 80'd0);
        tick();
        check("c3_issue", {49'd0, i0.instr_valid, i0.opcode, i0.op_a, i0.op_b, i0.pc},
              {49'd0, 1'b1, 4'd2, 5'd0, 5'd31, 16'd0});
        s = snap();
        repeat (5) begin
            tick();
            check("frozen", {15'd0, snap()}, {15'd0, s});
        end
        i0.exec_ready = 1'b1;
        tick();
        i0.exec_ready = 1'b0;
        check("xfer", {61'd0, i0.instr_valid, i0.Control, i0.InstrAddr}, {61'd0, 1'b0, 2'd1, 16'd1});
        tick();
        tick();
        check("imm_fetch", {62'd0, i0.Control, i0.InstrAddr}, {62'd0, 2'd1, 16'd2});
        tick();
        tick();
        check("load_issue", {38'd0, i0.instr_valid, i0.opcode, i0.op_a, i0.op_b, i0.imm, i0.pc},
              {38'd0, 1'b1, 4'd4, 5'd0, 5'd1, 16'd7, 16'd1});
        i0.exec_ready = 1'b1;
        tick();
        check("after_load", {62'd0, i0.Control, i0.InstrAddr}, {62'd0, 2'd1, 16'd3});
        check("one_xfer_each", issued - base, 2);
        tick();
        tick();
        check("end_halt", {75'd0, i0.halted, i0.addr_err, i0.Control, i0.instr_valid}, {75'd0, 5'b10000});
        pulse_start();
        repeat (3) tick();
        check("halt_absorb", {75'd0, i0.halted, i0.addr_err, i0.Control, i0.instr_valid}, {75'd0, 5'b10000});

        pulse_start1: begin
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
        end
        check("u1_fetch63", {62'd0, i1.Control, i1.InstrAddr}, {62'd0, 2'd1, 16'd63});
        for (int c = 0; c < 10 && !i1.addr_err; c++) tick();
        check("u1_addr_err", {75'd0, i1.addr_err, i1.halted, i1.instr_valid, i1.Control}, {75'd0, 5'b10000});

        // JMPZ at 51 with target 32; everything before it is NOP.
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 128; i++) mem[i] = 16'd0;
            mem[51] = 16'hF000;
            mem[52] = 16'd32;
            zf = z[0];
            do_reset();
            i0.exec_ready = 1'b1;
            i0.zero_flag = zf;
            fetchq.delete();
            base = issued;
            pulse_start();
            k = -1;
            for (int c = 0; c < 400; c++) begin
                k = -1;
                foreach (fetchq[j]) if (k < 0 && fetchq[j] == 16'd52) k = j;
                if (k >= 0 && fetchq.size() > k + 1) break;
                tick();
            end
            check("jmpz_seen", {79'd0, k >= 0 && fetchq.size() > k + 1}, 80'd1);
            if (k >= 0 && fetchq.size() > k + 1)
                check("jmpz_target", {64'd0, fetchq[k + 1]}, zf ? 80'd53 : 80'd32);
            check("jmpz_no_valid", issued - base, 0);
        end

        // Reset pulsed while the first read is outstanding.
        for (int i = 0; i < 128; i++) mem[i] = 16'd0;
        mem[0] = 16'b0010000001111100;
        do_reset();
        i0.exec_ready = 1'b1;
        pulse_start();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        base = issued;
        repeat (4) begin
            tick();
            check("abort_quiet", {77'd0, i0.instr_valid, i0.Control}, 80'd0);
        end
        check("abort_no_issue", issued - base, 0);
        pulse_start();
        check("restart_fetch", {62'd0, i0.Control, i0.InstrAddr}, {62'd0, 2'd1, 16'd0});
        tick();
        tick();
        check("restart_issue", {59'd0, i0.instr_valid, i0.opcode, i0.pc}, {59'd0, 1'b1, 4'd2, 16'd0});

        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 64; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd1 && $urandom_range(0, 3) != 0) op = 4'd2;
                mem[i] = {op, 12'($urandom)};
            end
            for (int i = 0; i < 63; i++) if (mem[i][15:12] == 4'd15) mem[i + 1] = 16'($urandom_range(0, 70));
            zf = 1'($urandom_range(0, 1));
            expq.delete();
            do_reset();
            build_model(zf, st, n);
            i0.zero_flag = zf;
            sb_on = 1'b1;
            base = issued;
            pulse_start();
            for (int c = 0; c < 4000; c++) begin
                if (i0.halted || i0.addr_err || (st == 0 && issued - base >= n)) break;
                i0.exec_ready = 1'($urandom_range(0, 1));
                tick();
            end
            check("rnd_outcome", {78'd0, i0.halted, i0.addr_err}, {78'd0, st == 1, st == 2});
            check("rnd_count", issued - base, n);
            check("rnd_drained", expq.size(), 0);
            sb_on = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
